tone_sequencer: RTL and testbench

Bus initiator that drives the tone generator's register-write port (`write_strobe`/`address`/`data`) from a small programmable step table. At a programmable tempo it plays one step at a time. Each step is emitted as a fixed burst of three single-cycle register writes: period, channel-A volume, and channel enables. The block sits between the host or pin-level control logic and the signal generator, turning a stored pattern into autonomous register traffic.

---
 rtl/tone_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_tone_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// ---------------------------------------------------------------------------
// tone_sequencer
//
// Plays a small programmable step table as register traffic toward the tone
// generator. Each step becomes an atomic burst of three single-cycle register
// writes (period, channel-A volume, channel enables), and consecutive steps
// are spaced by a programmable tempo.
//
// Configuration macro: TONE_SEQ_LOOP_EN
//   defined   - the sequence wraps from step `length` back to step 0 while
//               `run` stays high; `done` is tied low.
//   undefined - the sequence stops after step `length`, raises `done`, and
//               stays blocked until `run` is seen low (or reset).
//
// Parameters:
//   DEPTH    number of step-table entries (power of two, >= 2)
//   TEMPO_W  width of the tempo field and interval counter (>= 3)
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   prog_we      write one step-table entry this cycle
//   prog_addr    entry index for prog_we
//   prog_data    entry contents {period[4:0], vol[3:0], enA, enN}
//   tempo        step interval minus one, in clk cycles (clamped to >= 3)
//   length       index of the last step played
//   run          level: high = play, low = stop at the next burst boundary
//   write_strobe one-cycle register-write strobe toward the generator
//   address      register address, zero while write_strobe is low
//   data         register data, zero while write_strobe is low
//   step_idx     index of the step most recently fetched
//   busy         high in every state except IDLE
//   done         sequence finished (non-loop build only)
// ---------------------------------------------------------------------------
module tone_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TEMPO_W = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [10:0]        prog_data,
    input  logic [TEMPO_W-1:0] tempo,
    input  logic [AW-1:0]      length,
    input  logic               run,
    output logic               write_strobe,
    output logic [2:0]         address,
    output logic [4:0]         data,
    output logic [AW-1:0]      step_idx,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WR_PER,
        S_WR_VOL,
        S_WR_EN,
        S_WAIT
    } state_t;

    // Register addresses inside the tone generator
    localparam logic [2:0] ADDR_PERIOD = 3'b000;
    localparam logic [2:0] ADDR_VOL_A  = 3'b010;
    localparam logic [2:0] ADDR_ENABLE = 3'b101;

    // Shortest legal interval: the three writes plus the fetch cycle
    localparam logic [TEMPO_W-1:0] TEMPO_MIN  = TEMPO_W'(3);
    // Burst and fetch cycles that are not spent in WAIT, plus one for the
    // zero-terminated countdown
    localparam logic [TEMPO_W-1:0] WAIT_OFFS  = TEMPO_W'(4);

    logic [10:0]        step_table_q [DEPTH];
    logic [10:0]        fetch_word;

    state_t             state_q;
    logic [AW-1:0]      step_idx_q;
    logic [5:0]         vol_en_q;
    logic [TEMPO_W-1:0] tempo_q;
    logic [TEMPO_W-1:0] cnt_q;
    logic               strobe_q;
    logic [2:0]         address_q;
    logic [4:0]         data_q;
    logic               busy_q;
    logic               done_w;

    logic [TEMPO_W-1:0] tempo_eff;
    logic               expire_now;
    state_t             exp_state_d;
    logic [AW-1:0]      exp_idx_d;

`ifndef TONE_SEQ_LOOP_EN
    logic               done_q;
    logic               exp_done_d;
`endif

    // Step table storage. The write is a plain synchronous write, so a fetch
    // of the same entry in the same cycle naturally sees the old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                step_table_q[i] <= '0;
            end
        end else if (prog_we) begin
            step_table_q[prog_addr] <= prog_data;
        end
    end

    assign fetch_word = step_table_q[step_idx_q];

    // Short tempos are stretched so a burst and its fetch always fit inside
    // one step interval.
    assign tempo_eff = (tempo < TEMPO_MIN) ? TEMPO_MIN : tempo;

    // The interval ends either straight out of WR_EN (minimum tempo, no WAIT
    // cycles needed) or when the WAIT countdown reaches zero.
    assign expire_now = ((state_q == S_WR_EN) && (tempo_q == TEMPO_MIN)) ||
                        ((state_q == S_WAIT) && (cnt_q == '0));

    // Decision taken at the end of a step interval: stop, advance, or handle
    // the last step (wrap in the loop build, finish otherwise).
    always_comb begin
        exp_state_d = S_IDLE;
        exp_idx_d   = step_idx_q;
`ifndef TONE_SEQ_LOOP_EN
        exp_done_d  = 1'b0;
`endif
        if (!run) begin
            exp_state_d = S_IDLE;
        end else if (step_idx_q < length) begin
            exp_state_d = S_FETCH;
            exp_idx_d   = step_idx_q + 1'b1;
        end else begin
`ifdef TONE_SEQ_LOOP_EN
            exp_state_d = S_FETCH;
            exp_idx_d   = '0;
`else
            exp_state_d = S_IDLE;
            exp_done_d  = 1'b1;
`endif
        end
    end

`ifdef TONE_SEQ_LOOP_EN
    assign done_w = 1'b0;
`else
    assign done_w = done_q;
`endif

    // Main sequencer. Bus outputs are registered and default to zero every
    // cycle, so address/data only carry a value alongside the strobe. The
    // period goes out straight from the table word as it is fetched; volume
    // and enables come from the latched copy on the following two cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            step_idx_q <= '0;
            vol_en_q   <= '0;
            tempo_q    <= TEMPO_MIN;
            cnt_q      <= '0;
            strobe_q   <= 1'b0;
            address_q  <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
`ifndef TONE_SEQ_LOOP_EN
            done_q     <= 1'b0;
`endif
        end else begin
            strobe_q  <= 1'b0;
            address_q <= '0;
            data_q    <= '0;

            case (state_q)
                S_IDLE: begin
                    if (run && !done_w) begin
                        state_q    <= S_FETCH;
                        step_idx_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    vol_en_q  <= fetch_word[5:0];
                    strobe_q  <= 1'b1;
                    address_q <= ADDR_PERIOD;
                    data_q    <= fetch_word[10:6];
                    state_q   <= S_WR_PER;
                end
                S_WR_PER: begin
                    tempo_q   <= tempo_eff;
                    strobe_q  <= 1'b1;
                    address_q <= ADDR_VOL_A;
                    data_q    <= {1'b0, vol_en_q[5:2]};
                    state_q   <= S_WR_VOL;
                end
                S_WR_VOL: begin
                    strobe_q  <= 1'b1;
                    address_q <= ADDR_ENABLE;
                    data_q    <= {3'b000, vol_en_q[1:0]};
                    state_q   <= S_WR_EN;
                end
                S_WR_EN: begin
                    if (tempo_q != TEMPO_MIN) begin
                        cnt_q   <= tempo_q - WAIT_OFFS;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (expire_now) begin
                state_q    <= exp_state_d;
                step_idx_q <= exp_idx_d;
                busy_q     <= (exp_state_d != S_IDLE);
`ifndef TONE_SEQ_LOOP_EN
                if (exp_done_d) begin
                    done_q <= 1'b1;
                end
`endif
            end

`ifndef TONE_SEQ_LOOP_EN
            // A finished sequence stays blocked until run is seen low
            if (!run) begin
                done_q <= 1'b0;
            end
`endif
        end
    end

    assign write_strobe = strobe_q;
    assign address      = address_q;
    assign data         = data_q;
    assign step_idx     = step_idx_q;
    assign busy         = busy_q;
    assign done         = done_w;

endmodule

// File: tb/tb_tone_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tone_sequencer
//
// Self-checking bench for tone_sequencer. Each scenario task pushes the
// register writes it expects (with the exact cycle they must appear) onto a
// scoreboard queue; a negedge monitor pops and compares every strobe and
// checks that the bus is idle (zero) between strobes. Builds with or without
// TONE_SEQ_LOOP_EN; the end-of-sequence scenario adapts to the build.
// ---------------------------------------------------------------------------
module tb_tone_sequencer;

    logic        clk;
    logic        rst;
    logic        prog_we;
    logic [2:0]  prog_addr;
    logic [10:0] prog_data;
    logic [15:0] tempo;
    logic [2:0]  length;
    logic        run;
    logic        write_strobe;
    logic [2:0]  address;
    logic [4:0]  data;
    logic [2:0]  step_idx;
    logic        busy;
    logic        done;

    typedef struct {
        int         cyc;
        logic [2:0] addr;
        logic [4:0] data;
    } sbItem_t;

    sbItem_t     sbQ[$];
    sbItem_t     monItem;
    logic [10:0] shadow [8];
    int          cyc;
    int          checks;
    int          errors;
    logic        monEn;

    tone_sequencer #(
        .DEPTH   (8),
        .TEMPO_W (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .tempo        (tempo),
        .length       (length),
        .run          (run),
        .write_strobe (write_strobe),
        .address      (address),
        .data         (data),
        .step_idx     (step_idx),
        .busy         (busy),
        .done         (done)
    );

    // Free-running clock and a cycle counter used to time-stamp strobes
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every strobe must match the oldest expected write
    // both in content and in cycle; between strobes the bus must read zero.
    always @(negedge clk) begin
        if (monEn) begin
            checks++;
            if (write_strobe === 1'b1) begin
                if (sbQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_strobe cyc=%0d got addr=%0h data=%0h, expected no strobe",
                             cyc, address, data);
                end else begin
                    monItem = sbQ.pop_front();
                    if (monItem.cyc !== cyc || monItem.addr !== address || monItem.data !== data) begin
                        errors++;
                        $display("[TB] FAIL burst_write got cyc=%0d addr=%0h data=%0h, expected cyc=%0d addr=%0h data=%0h",
                                 cyc, address, data, monItem.cyc, monItem.addr, monItem.data);
                    end
                end
            end else if (write_strobe !== 1'b0 || address !== 3'd0 || data !== 5'd0) begin
                errors++;
                $display("[TB] FAIL idle_bus cyc=%0d got strobe=%b addr=%0h data=%0h, expected 0/0/0",
                         cyc, write_strobe, address, data);
            end
        end
    end

    // Hard stop in case a scenario never reaches its end
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cyc=%0d, expected the bench to finish", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCyc(input int c);
        while (cyc < c) tick();
    endtask

    // Writes one table entry while idle and mirrors it in the shadow table
    task automatic applyStimulus(input logic [2:0] a, input logic [10:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
        shadow[a] = d;
    endtask

    // Expected three-write burst for a table word, starting at cycle c
    task automatic pushBurst(input int c, input logic [10:0] e);
        sbItem_t it;
        it.cyc = c;     it.addr = 3'b000; it.data = e[10:6];            sbQ.push_back(it);
        it.cyc = c + 1; it.addr = 3'b010; it.data = {1'b0, e[5:2]};     sbQ.push_back(it);
        it.cyc = c + 2; it.addr = 3'b101; it.data = {3'b000, e[1:0]};   sbQ.push_back(it);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (write_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobe got %b expected 0", write_strobe); end
        checks++;
        if (address !== 3'd0) begin errors++; $display("[TB] FAIL reset_address got %0h expected 0", address); end
        checks++;
        if (data !== 5'd0) begin errors++; $display("[TB] FAIL reset_data got %0h expected 0", data); end
        checks++;
        if (step_idx !== 3'd0) begin errors++; $display("[TB] FAIL reset_step_idx got %0d expected 0", step_idx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done); end
        for (int i = 0; i < 8; i++) shadow[i] = 11'd0;
        monEn = 1'b1;
    endtask

    task automatic test_basic_step();
        int k;
        applyStimulus(3'd0, {5'h15, 4'h9, 1'b1, 1'b0});
        length = 3'd0;
        tempo  = 16'd9;
        k      = cyc;
        run    = 1'b1;
        pushBurst(k + 2, shadow[0]);
        waitCyc(k + 2);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_burst got %b expected 1", busy); end
        waitCyc(k + 5);
        run = 1'b0;
        waitCyc(k + 10);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_wait got %b expected 1", busy); end
        waitCyc(k + 11);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_end got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done got %b expected 0", done); end
        waitCyc(k + 25);
        checks++;
        if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL basic_missing_writes got %0d pending expected 0", sbQ.size()); sbQ.delete(); end
    endtask

    task automatic test_tempo_clamp();
        int k;
        applyStimulus(3'd0, {5'h0A, 4'h3, 1'b0, 1'b1});
        applyStimulus(3'd1, {5'h1F, 4'hC, 1'b1, 1'b1});
        length = 3'd1;
        tempo  = 16'd0;
        k      = cyc;
        run    = 1'b1;
        pushBurst(k + 2, shadow[0]);
        pushBurst(k + 6, shadow[1]);
        waitCyc(k + 7);
        run = 1'b0;
        waitCyc(k + 8);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL clamp_busy_burst got %b expected 1", busy); end
        waitCyc(k + 9);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL clamp_busy_end got %b expected 0", busy); end
        checks++;
        if (step_idx !== 3'd1) begin errors++; $display("[TB] FAIL clamp_step_idx got %0d expected 1", step_idx); end
        waitCyc(k + 20);
        checks++;
        if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL clamp_missing_writes got %0d pending expected 0", sbQ.size()); sbQ.delete(); end
    endtask

    task automatic test_stop_rule();
        int k;
        length = 3'd3;
        tempo  = 16'd9;
        k      = cyc;
        run    = 1'b1;
        pushBurst(k + 2, shadow[0]);
        waitCyc(k + 3);
        run = 1'b0;
        waitCyc(k + 10);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL stop_busy_wait got %b expected 1", busy); end
        waitCyc(k + 11);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stop_busy_end got %b expected 0", busy); end
        waitCyc(k + 30);
        checks++;
        if (step_idx !== 3'd0) begin errors++; $display("[TB] FAIL stop_step_idx got %0d expected 0", step_idx); end
        checks++;
        if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL stop_missing_writes got %0d pending expected 0", sbQ.size()); sbQ.delete(); end
    endtask

`ifdef TONE_SEQ_LOOP_EN
    task automatic test_loop();
        int k;
        length = 3'd1;
        tempo  = 16'd9;
        k      = cyc;
        run    = 1'b1;
        for (int s = 0; s < 4; s++) pushBurst(k + 2 + 10 * s, shadow[s % 2]);
        for (int s = 0; s < 4; s++) begin
            waitCyc(k + 2 + 10 * s);
            checks++;
            if (step_idx !== 3'(s % 2)) begin
                errors++;
                $display("[TB] FAIL loop_step_idx pass=%0d got %0d expected %0d", s, step_idx, s % 2);
            end
        end
        waitCyc(k + 33);
        run = 1'b0;
        waitCyc(k + 41);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL loop_busy_end got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL loop_done got %b expected 0", done); end
        waitCyc(k + 55);
        checks++;
        if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL loop_missing_writes got %0d pending expected 0", sbQ.size()); sbQ.delete(); end
    endtask
`else
    task automatic test_done();
        int k;
        int m;
        applyStimulus(3'd2, {5'h07, 4'h5, 1'b1, 1'b0});
        length = 3'd2;
        tempo  = 16'd5;
        k      = cyc;
        run    = 1'b1;
        pushBurst(k + 2,  shadow[0]);
        pushBurst(k + 8,  shadow[1]);
        pushBurst(k + 14, shadow[2]);
        waitCyc(k + 18);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL done_last_wait got busy=%b done=%b expected 1/0", busy, done); end
        waitCyc(k + 19);
        checks++;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL done_set got %b expected 1", done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL done_busy got %b expected 0", busy); end
        waitCyc(k + 30);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL done_hold got done=%b busy=%b expected 1/0", done, busy); end
        m   = cyc;
        run = 1'b0;
        waitCyc(m + 1);
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_clear got %b expected 0", done); end
        waitCyc(m + 3);
        run = 1'b1;
        pushBurst(m + 5, shadow[0]);
        waitCyc(m + 4);
        run = 1'b0;
        waitCyc(m + 5);
        checks++;
        if (step_idx !== 3'd0) begin errors++; $display("[TB] FAIL done_restart_idx got %0d expected 0", step_idx); end
        waitCyc(m + 25);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL done_restart_end got busy=%b done=%b expected 0/0", busy, done); end
        checks++;
        if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL done_missing_writes got %0d pending expected 0", sbQ.size()); sbQ.delete(); end
    endtask
`endif

    task automatic test_reset_mid_burst();
        int k;
        sbItem_t it;
        applyStimulus(3'd0, {5'h19, 4'hA, 1'b1, 1'b1});
        length = 3'd0;
        tempo  = 16'd9;
        k      = cyc;
        run    = 1'b1;
        it.cyc = k + 2; it.addr = 3'b000; it.data = shadow[0][10:6];
        sbQ.push_back(it);
        waitCyc(k + 2);
        rst = 1'b1;
        run = 1'b0;
        waitCyc(k + 3);
        checks++;
        if (write_strobe !== 1'b0 || address !== 3'd0 || data !== 5'd0) begin
            errors++;
            $display("[TB] FAIL rst_mid_bus got strobe=%b addr=%0h data=%0h expected 0/0/0", write_strobe, address, data);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || step_idx !== 3'd0) begin
            errors++;
            $display("[TB] FAIL rst_mid_status got busy=%b done=%b idx=%0d expected 0/0/0", busy, done, step_idx);
        end
        waitCyc(k + 4);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) shadow[i] = 11'd0;
        waitCyc(k + 5);
        run = 1'b1;
        pushBurst(k + 7, shadow[0]);
        waitCyc(k + 6);
        run = 1'b0;
        waitCyc(k + 25);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_readback_busy got %b expected 0", busy); end
        checks++;
        if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL rst_missing_writes got %0d pending expected 0", sbQ.size()); sbQ.delete(); end
    endtask

    task automatic test_prog_collision();
        int k;
        logic [10:0] newWord;
        newWord = {5'h0C, 4'h6, 1'b0, 1'b1};
        applyStimulus(3'd0, {5'h13, 4'hE, 1'b1, 1'b0});
        length = 3'd0;
        tempo  = 16'd5;
        k      = cyc;
        run    = 1'b1;
        pushBurst(k + 2, shadow[0]);
        waitCyc(k + 1);
        prog_we   = 1'b1;
        prog_addr = 3'd0;
        prog_data = newWord;
        waitCyc(k + 2);
        prog_we   = 1'b0;
        shadow[0] = newWord;
        waitCyc(k + 3);
        run = 1'b0;
        waitCyc(k + 10);
        run = 1'b1;
        pushBurst(k + 12, shadow[0]);
        waitCyc(k + 11);
        run = 1'b0;
        waitCyc(k + 30);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL collision_busy got %b expected 0", busy); end
        checks++;
        if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL collision_missing_writes got %0d pending expected 0", sbQ.size()); sbQ.delete(); end
    endtask

    // Scenario sequence
    initial begin
        checks    = 0;
        errors    = 0;
        monEn     = 1'b0;
        rst       = 1'b1;
        run       = 1'b0;
        prog_we   = 1'b0;
        prog_addr = 3'd0;
        prog_data = 11'd0;
        tempo     = 16'd9;
        length    = 3'd0;

        test_reset();
        test_basic_step();
        test_tempo_clamp();
        test_stop_rule();
`ifdef TONE_SEQ_LOOP_EN
        test_loop();
`else
        test_done();
`endif
        test_reset_mid_burst();
        test_prog_collision();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
